// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG zig-zag/RLE stage: scan table, FSM states, symbol record.
// The symbol record is sized for the default amplitude width.
package jpeg_pkg;

   localparam int AMP_W_DEF = 12;
   localparam int RUN_W     = 4;
   localparam int SIZE_W    = 4;

   // Scan position -> natural index (8*row + col)
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_EV,
      S_EMIT,
      S_DONE
   } rle_state_t;

   typedef struct packed {
      logic                 dc;
      logic [RUN_W-1:0]     run;
      logic [SIZE_W-1:0]    size;
      logic [AMP_W_DEF-1:0] amp;
   } rle_sym_t;

endpackage

// File: rtl/jpeg_sizecat.sv
// Combinational value -> (size category, amplitude bits) encoder, zero latency.
// Negative values use the one's-complement form; unused amplitude MSBs are zero.
module jpeg_sizecat
   import jpeg_pkg::*;
#(
   parameter int AMP_W = AMP_W_DEF
) (
   input  logic signed [AMP_W:0]   v_i,
   output logic [SIZE_W-1:0]       size_o,
   output logic [AMP_W-1:0]        amp_o
);

   logic [AMP_W:0]   mag;
   logic [AMP_W-1:0] amp_raw;
   logic [AMP_W-1:0] mask;

   always_comb begin
      mag     = v_i[AMP_W] ? (AMP_W+1)'(-v_i) : v_i;
      amp_raw = v_i[AMP_W] ? AMP_W'(v_i - (AMP_W+1)'(1)) : v_i[AMP_W-1:0];

      size_o = '0;
      for (int i = 0; i <= AMP_W; i++) begin
         if (mag[i]) size_o = SIZE_W'(i + 1);
      end

      mask = '0;
      for (int i = 0; i < AMP_W; i++) begin
         if (i < int'(size_o)) mask[i] = 1'b1;
      end

      amp_o = amp_raw & mask;
   end

endmodule

// File: rtl/jpeg_rle.sv
// Zig-zag scan + baseline-JPEG run-length coder for one 8x8 block, DC predictor kept across blocks.
// Two cycles per coefficient read, one per emitted symbol; EMIT holds the symbol until sym_ready_i.
module jpeg_rle
   import jpeg_pkg::*;
#(
   parameter int AMP_W = AMP_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             clr_pred_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [4:0]       mem_adr_o,
   input  logic [31:0]      mem_dat_i,
   output logic             sym_valid_o,
   input  logic             sym_ready_i,
   output logic             sym_dc_o,
   output logic [3:0]       sym_run_o,
   output logic [3:0]       sym_size_o,
   output logic [AMP_W-1:0] sym_amp_o
);

   localparam logic signed [15:0] SAT = 16'((1 << (AMP_W - 1)) - 1);

   rle_state_t              state_q, state_d;
   logic [5:0]              p_q, p_nxt;
   logic [5:0]              run_q;
   logic                    zrl_q;
   rle_sym_t                sym_q;
   logic signed [AMP_W-1:0] pred_q;
   logic [4:0]              adr_q;
   logic                    done_q;

   logic                    k_odd;
   logic signed [15:0]      coef_raw;
   logic signed [AMP_W-1:0] coef_sat;
   logic                    coef_zero;
   logic                    last;
   logic [AMP_W:0]          cat_in;
   logic [SIZE_W-1:0]       cat_size;
   logic [AMP_W-1:0]        cat_amp;

   always_comb begin
      k_odd    = ZZ[p_q][0];
      coef_raw = k_odd ? mem_dat_i[15:0] : mem_dat_i[31:16];
      if (coef_raw > SAT)
         coef_sat = AMP_W'(SAT);
      else if (coef_raw < -SAT)
         coef_sat = AMP_W'(-SAT);
      else
         coef_sat = coef_raw[AMP_W-1:0];
      coef_zero = (coef_sat == '0);
      last      = (p_q == 6'd63);
      p_nxt     = p_q + 6'd1;
      // DC difference needs one extra bit: both operands are within +/-(2^(AMP_W-1)-1)
      if (p_q == 6'd0)
         cat_in = {coef_sat[AMP_W-1], coef_sat} - {pred_q[AMP_W-1], pred_q};
      else
         cat_in = {coef_sat[AMP_W-1], coef_sat};
   end

   jpeg_sizecat #(.AMP_W(AMP_W)) u_sizecat (
      .v_i    (cat_in),
      .size_o (cat_size),
      .amp_o  (cat_amp)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_i) state_d = S_RD;
         S_RD:   state_d = S_EV;
         S_EV: begin
            if (p_q == 6'd0)     state_d = S_EMIT;
            else if (coef_zero)  state_d = last ? S_EMIT : S_RD;
            else                 state_d = S_EMIT;
         end
         S_EMIT: begin
            if (sym_ready_i) begin
               if (zrl_q)     state_d = S_RD;
               else if (last) state_d = S_DONE;
               else           state_d = S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != S_IDLE);
      sym_valid_o = (state_q == S_EMIT);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         p_q    <= '0;
         run_q  <= '0;
         zrl_q  <= 1'b0;
         sym_q  <= '0;
         pred_q <= '0;
         adr_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (clr_pred_i) pred_q <= '0;
               if (start_i) begin
                  p_q   <= '0;
                  run_q <= '0;
                  zrl_q <= 1'b0;
                  adr_q <= ZZ[0][5:1];
               end
            end
            S_EV: begin
               if (p_q == 6'd0) begin
                  sym_q  <= '{dc: 1'b1, run: '0, size: cat_size, amp: AMP_W_DEF'(cat_amp)};
                  pred_q <= coef_sat;
               end else if (coef_zero) begin
                  run_q <= run_q + 6'd1;
                  if (last) begin
                     sym_q <= '0;
                  end else begin
                     p_q   <= p_nxt;
                     adr_q <= ZZ[p_nxt][5:1];
                  end
               end else if (run_q >= 6'd16) begin
                  // ZRL: the same coefficient is re-read after this symbol is taken
                  sym_q <= '{dc: 1'b0, run: 4'd15, size: '0, amp: '0};
                  run_q <= run_q - 6'd16;
                  zrl_q <= 1'b1;
               end else begin
                  sym_q <= '{dc: 1'b0, run: run_q[3:0], size: cat_size, amp: AMP_W_DEF'(cat_amp)};
                  run_q <= '0;
               end
            end
            S_EMIT: begin
               if (sym_ready_i) begin
                  if (zrl_q) begin
                     zrl_q <= 1'b0;
                  end else if (!last) begin
                     p_q   <= p_nxt;
                     adr_q <= ZZ[p_nxt][5:1];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign done_o     = done_q;
   assign mem_adr_o  = adr_q;
   assign sym_dc_o   = sym_q.dc;
   assign sym_run_o  = sym_q.run;
   assign sym_size_o = sym_q.size;
   assign sym_amp_o  = sym_q.amp[AMP_W-1:0];

endmodule

// File: tb/tb_jpeg_rle.sv
// Bench for jpeg_rle: directed blocks, expected symbols queued at stimulus time and
// checked by an independent monitor on every accepted handshake.
module tb_jpeg_rle;

   logic        clk = 1'b0;
   logic        rst_n, start, clr_pred;
   logic        busy, done, sym_valid, sym_ready, sym_dc;
   logic [4:0]  mem_adr;
   logic [31:0] mem_dat;
   logic [3:0]  sym_run, sym_size;
   logic [11:0] sym_amp;
   logic [31:0] mem [32];

   always #5 clk = ~clk;

   jpeg_rle #(.AMP_W(12)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .clr_pred_i  (clr_pred),
      .busy_o      (busy),
      .done_o      (done),
      .mem_adr_o   (mem_adr),
      .mem_dat_i   (mem_dat),
      .sym_valid_o (sym_valid),
      .sym_ready_i (sym_ready),
      .sym_dc_o    (sym_dc),
      .sym_run_o   (sym_run),
      .sym_size_o  (sym_size),
      .sym_amp_o   (sym_amp)
   );

   always @(posedge clk) mem_dat <= mem[mem_adr];

   typedef struct packed {
      logic        dc;
      logic [3:0]  run;
      logic [3:0]  size;
      logic [11:0] amp;
   } sym_t;

   sym_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic sym_t mk(input logic dc, input int run, input int size, input int amp);
      sym_t s;
      s.dc   = dc;
      s.run  = 4'(run);
      s.size = 4'(size);
      s.amp  = 12'(amp);
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: scoreboard pop on accept, stability check while stalled
   sym_t mon_cur, mon_held, mon_exp;
   bit   hold_vld = 1'b0;
   always @(negedge clk) begin
      mon_cur = {sym_dc, sym_run, sym_size, sym_amp};
      if (!rst_n) begin
         hold_vld = 1'b0;
      end else begin
         if (hold_vld) begin
            n_tests++;
            if (sym_valid !== 1'b1 || mon_cur !== mon_held) begin
               n_fail++;
               $display("FAIL hold_stable: got valid=%0b sym=%h required valid=1 sym=%h",
                        sym_valid, mon_cur, mon_held);
            end
         end
         if (sym_valid && sym_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got sym=%h required no symbol", mon_cur);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_cur !== mon_exp) begin
                  n_fail++;
                  $display("FAIL sym: got dc=%0b run=%0d size=%0d amp=%h required dc=%0b run=%0d size=%0d amp=%h",
                           mon_cur.dc, mon_cur.run, mon_cur.size, mon_cur.amp,
                           mon_exp.dc, mon_exp.run, mon_exp.size, mon_exp.amp);
               end
            end
            hold_vld = 1'b0;
         end else if (sym_valid) begin
            mon_held = mon_cur;
            hold_vld = 1'b1;
         end else begin
            hold_vld = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = '0;
   endtask

   task automatic set_coef(input int k, input int val);
      if (k % 2 == 0) mem[k / 2][31:16] = 16'(val);
      else            mem[k / 2][15:0]  = 16'(val);
   endtask

   // exp_cyc < 0 skips the latency check
   task automatic run_block(input string name, input int exp_cyc, input logic with_clr);
      int cyc;
      start    = 1'b1;
      clr_pred = with_clr;
      step(1);
      start    = 1'b0;
      clr_pred = 1'b0;
      cyc      = 1;
      chk({name, "_busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 3000) begin
         step(1);
         cyc++;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no done_o after %0d cycles required done_o", name, cyc);
      end else if (exp_cyc > 0) begin
         chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
      end
      step(1);
      chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   task automatic stall_first();
      for (int i = 0; i < 100 && !sym_valid; i++) step(1);
      step(5);
      sym_ready = 1'b1;
   endtask

   task automatic pulse_clr();
      clr_pred = 1'b1;
      step(1);
      clr_pred = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_mem();
      rst_n     = 1'b0;
      start     = 1'b0;
      clr_pred  = 1'b0;
      sym_ready = 1'b1;
      step(3);
      chk("rst_outputs", {26'd0, busy, done, sym_valid, sym_dc, 2'd0}, 32'd0);
      chk("rst_adr", 32'(mem_adr), 32'd0);
      chk("rst_fields", {12'd0, sym_run, sym_size, sym_amp}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // all-zero block
      exp_q.push_back(mk(1, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("zero", 132, 1'b0);

      // DC=5, zz[1]=-3 with first symbol stalled
      clear_mem();
      set_coef(0, 5);
      set_coef(1, -3);
      exp_q.push_back(mk(1, 0, 3, 'b101));
      exp_q.push_back(mk(0, 0, 2, 'b00));
      exp_q.push_back(mk(0, 0, 0, 0));
      sym_ready = 1'b0;
      fork
         run_block("dc5", -1, 1'b0);
         stall_first();
      join

      // predictor carried: 2 - 5 = -3
      clear_mem();
      set_coef(0, 2);
      exp_q.push_back(mk(1, 0, 2, 'b00));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("dc2", 132, 1'b0);

      // zz[40] (k=29) = 1 after clearing the predictor
      pulse_clr();
      clear_mem();
      set_coef(29, 1);
      exp_q.push_back(mk(1, 0, 0, 0));
      exp_q.push_back(mk(0, 15, 0, 0));
      exp_q.push_back(mk(0, 15, 0, 0));
      exp_q.push_back(mk(0, 7, 1, 1));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("zz40", 139, 1'b0);

      // zz[63] = -1: no EOB
      clear_mem();
      set_coef(63, -1);
      exp_q.push_back(mk(1, 0, 0, 0));
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 15, 0, 0));
      exp_q.push_back(mk(0, 14, 1, 0));
      run_block("zz63", 141, 1'b0);

      // saturation, both half-words, short run
      clear_mem();
      set_coef(0, 3000);
      set_coef(1, -30000);
      set_coef(8, 1);
      set_coef(3, 4);
      exp_q.push_back(mk(1, 0, 11, 'h7FF));
      exp_q.push_back(mk(0, 0, 11, 'h000));
      exp_q.push_back(mk(0, 0, 1, 1));
      exp_q.push_back(mk(0, 3, 3, 'b100));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("sat", -1, 1'b0);

      // DC diff -2047 - 2047 = -4094 (size 12), saturated last coefficient
      clear_mem();
      set_coef(0, -5000);
      set_coef(63, 32767);
      exp_q.push_back(mk(1, 0, 12, 'h001));
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 15, 0, 0));
      exp_q.push_back(mk(0, 14, 11, 'h7FF));
      run_block("size12", -1, 1'b0);

      // reset mid-block while a symbol is pending
      clear_mem();
      set_coef(0, 7);
      sym_ready = 1'b0;
      start     = 1'b1;
      step(1);
      start = 1'b0;
      for (int i = 0; i < 50 && !sym_valid; i++) step(1);
      chk("mid_valid", 32'(sym_valid), 32'd1);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("mid_rst_state", {30'd0, sym_valid, busy}, 32'd0);
      begin
         int seen_done = 0;
         for (int i = 0; i < 200; i++) begin
            if (done) seen_done++;
            step(1);
         end
         chk("mid_rst_no_done", 32'(seen_done), 32'd0);
      end
      sym_ready = 1'b1;

      // predictor zero after reset
      exp_q.push_back(mk(1, 0, 3, 'b111));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("dc7_rst", 132, 1'b0);

      // predictor cleared between blocks
      pulse_clr();
      exp_q.push_back(mk(1, 0, 3, 'b111));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("dc7_clr", 132, 1'b0);

      // clear together with start
      exp_q.push_back(mk(1, 0, 3, 'b111));
      exp_q.push_back(mk(0, 0, 0, 0));
      run_block("dc7_clr_start", 132, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
